// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: grants the single register-file write port to one of EX, LSU load or MUL/DIV
// with starvation promotion. Optional pending-write scoreboard is enabled by defining WB_SCOREBOARD_EN.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ex_sel,
    input  logic [4:0]  ex_rd,
    output logic        ex_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    output logic        ld_ready,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    output logic        md_ready,
    output logic [2:0]  wb_sel,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic        sel_err,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] rd_busy
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    localparam logic [2:0] SEL_RTYPE = 3'b000;
    localparam logic [2:0] SEL_LD    = 3'b001;
    localparam logic [2:0] SEL_AUIPC = 3'b010;
    localparam logic [2:0] SEL_JAL   = 3'b011;
    localparam logic [2:0] SEL_MD    = 3'b111;

    // Handshake: a transfer happens when valid && ready in the same cycle. ready is
    // combinational from valids and wait counters only; producers hold valid/rd until ready.
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic [CW-1:0] ex_cnt_q, ex_cnt_d;
    logic [2:0]    wb_sel_q, wb_sel_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_rd_q, rf_rd_d;
    logic          sel_err_q, sel_err_d;

    logic ld_gnt, md_gnt, ex_gnt;
    logic md_prom, ex_prom;
    logic ex_sel_legal;

    assign md_prom      = md_valid && (md_cnt_q == CNT_MAX);
    assign ex_prom      = ex_valid && (ex_cnt_q == CNT_MAX);
    assign ex_sel_legal = (ex_sel == SEL_RTYPE) || (ex_sel == SEL_AUIPC) || (ex_sel == SEL_JAL);

    always_comb begin
        ld_gnt = 1'b0;
        md_gnt = 1'b0;
        ex_gnt = 1'b0;
        if (!rst) begin
            if (md_prom)       md_gnt = 1'b1;
            else if (ex_prom)  ex_gnt = 1'b1;
            else if (ld_valid) ld_gnt = 1'b1;
            else if (md_valid) md_gnt = 1'b1;
            else if (ex_valid) ex_gnt = 1'b1;
        end
    end

    assign ld_ready = ld_gnt;
    assign md_ready = md_gnt;
    assign ex_ready = ex_gnt;

    // Counters only accumulate while a requester is actually being held off.
    always_comb begin
        md_cnt_d = '0;
        ex_cnt_d = '0;
        if (md_valid && !md_gnt)
            md_cnt_d = (md_cnt_q == CNT_MAX) ? CNT_MAX : md_cnt_q + 1'b1;
        if (ex_valid && !ex_gnt)
            ex_cnt_d = (ex_cnt_q == CNT_MAX) ? CNT_MAX : ex_cnt_q + 1'b1;
    end

    always_comb begin
        wb_sel_d  = wb_sel_q;
        rf_rd_d   = rf_rd_q;
        rf_we_d   = 1'b0;
        sel_err_d = sel_err_q;
        if (ld_gnt) begin
            wb_sel_d = SEL_LD;
            rf_rd_d  = ld_rd;
            rf_we_d  = (ld_rd != 5'd0);
        end else if (md_gnt) begin
            wb_sel_d = SEL_MD;
            rf_rd_d  = md_rd;
            rf_we_d  = (md_rd != 5'd0);
        end else if (ex_gnt) begin
            wb_sel_d = ex_sel_legal ? ex_sel : SEL_RTYPE;
            rf_rd_d  = ex_rd;
            rf_we_d  = (ex_rd != 5'd0);
            if (!ex_sel_legal) sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q  <= '0;
            ex_cnt_q  <= '0;
            wb_sel_q  <= 3'b000;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= 5'd0;
            sel_err_q <= 1'b0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            ex_cnt_q  <= ex_cnt_d;
            wb_sel_q  <= wb_sel_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign wb_sel  = wb_sel_q;
    assign rf_we   = rf_we_q;
    assign rf_rd   = rf_rd_q;
    assign sel_err = sel_err_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] rd_busy_q, rd_busy_d;

    // Set is applied after clear so a re-issue of the register being written back stays busy.
    always_comb begin
        rd_busy_d = rd_busy_q;
        if (rf_we_q)
            rd_busy_d[rf_rd_q] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0))
            rd_busy_d[issue_rd] = 1'b1;
        rd_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_busy_q <= '0;
        else     rd_busy_q <= rd_busy_d;
    end

    assign rd_busy = rd_busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_rd};
    assign rd_busy      = 32'd0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table for single transfers plus
// sequences for starvation, illegal select, reset-in-flight and the optional scoreboard.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ld_valid, md_valid;
  logic [2:0]  ex_sel;
  logic [4:0]  ex_rd, ld_rd, md_rd;
  logic        ex_ready, ld_ready, md_ready;
  logic [2:0]  wb_sel;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic        sel_err;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] rd_busy;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_sel(ex_sel), .ex_rd(ex_rd), .ex_ready(ex_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_ready(md_ready),
    .wb_sel(wb_sel), .rf_we(rf_we), .rf_rd(rf_rd), .sel_err(sel_err),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rd_busy(rd_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       ld_v;
    logic [4:0] ld_r;
    logic       md_v;
    logic [4:0] md_r;
    logic       ex_v;
    logic [2:0] ex_s;
    logic [4:0] ex_r;
    logic [2:0] exp_rdy;  // {ld, md, ex}
    logic [2:0] exp_sel;
    logic       exp_we;
    logic [4:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [4:0] lr, input logic mv, input logic [4:0] mr,
                       input logic ev, input logic [2:0] es, input logic [4:0] er);
    ld_valid = lv; ld_rd = lr;
    md_valid = mv; md_rd = mr;
    ex_valid = ev; ex_sel = es; ex_rd = er;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    issue_valid = 1'b0;
    issue_rd = 5'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [2:0] rdy();
    return {ld_ready, md_ready, ex_ready};
  endfunction

  initial begin
    logic [2:0] seq_rdy[7];
    logic [2:0] seq_sel[7];

    vecs[0] = '{1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 3'b000, 5'd0,  3'b100, 3'b001, 1'b1, 5'd5};
    vecs[1] = '{1'b0, 5'd0,  1'b1, 5'd9,  1'b0, 3'b000, 5'd0,  3'b010, 3'b111, 1'b1, 5'd9};
    vecs[2] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 3'b000, 5'd3,  3'b001, 3'b000, 1'b1, 5'd3};
    vecs[3] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 3'b010, 5'd31, 3'b001, 3'b010, 1'b1, 5'd31};
    vecs[4] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 3'b011, 5'd0,  3'b001, 3'b011, 1'b0, 5'd0};
    vecs[5] = '{1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 3'b000, 5'd14, 3'b100, 3'b001, 1'b1, 5'd12};
    vecs[6] = '{1'b0, 5'd0,  1'b1, 5'd20, 1'b1, 3'b010, 5'd21, 3'b010, 3'b111, 1'b1, 5'd20};
    vecs[7] = '{1'b1, 5'd1,  1'b0, 5'd0,  1'b1, 3'b011, 5'd2,  3'b100, 3'b001, 1'b1, 5'd1};
    vecs[8] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 3'b000, 5'd0,  3'b000, 3'b001, 1'b0, 5'd1};

    do_reset();
    check("reset_wb_sel", 32'(wb_sel), 32'd0);
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_rf_rd", 32'(rf_rd), 32'd0);
    check("reset_sel_err", 32'(sel_err), 32'd0);
    check("reset_rd_busy", rd_busy, 32'd0);

    // single-transfer table, each vector followed by an idle cycle
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ld_v, vecs[i].ld_r, vecs[i].md_v, vecs[i].md_r,
            vecs[i].ex_v, vecs[i].ex_s, vecs[i].ex_r);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(rdy()), 32'(vecs[i].exp_rdy));
      step();
      drive_idle();
      check($sformatf("vec%0d_wb_sel", i), 32'(wb_sel), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_rf_rd", i), 32'(rf_rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_sel_err", i), 32'(sel_err), 32'd0);
      step();
      check($sformatf("vec%0d_idle_we", i), 32'(rf_we), 32'd0);
      check($sformatf("vec%0d_idle_rd", i), 32'(rf_rd), 32'(vecs[i].exp_rd));
    end

    // starvation: ld held every cycle, md and ex waiting
    seq_rdy = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100};
    seq_sel = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b111, 3'b010, 3'b001};
    drive(1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 3'b010, 5'd8);
    for (int i = 0; i < 7; i++) begin
      #1;
      check($sformatf("starve%0d_ready", i), 32'(rdy()), 32'(seq_rdy[i]));
      step();
      check($sformatf("starve%0d_wb_sel", i), 32'(wb_sel), 32'(seq_sel[i]));
    end
    drive_idle();
    step();

    // illegal ex_sel: granted, select forced to R-type, sticky error
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'b101, 5'd10);
    #1;
    check("illegal_ready", 32'(rdy()), 32'b001);
    step();
    drive_idle();
    check("illegal_wb_sel", 32'(wb_sel), 32'd0);
    check("illegal_rf_rd", 32'(rf_rd), 32'd10);
    check("illegal_rf_we", 32'(rf_we), 32'd1);
    check("illegal_sel_err", 32'(sel_err), 32'd1);
    step();
    step();
    check("sel_err_sticky", 32'(sel_err), 32'd1);

    // reset while md is waiting with a nonzero counter
    drive(1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 3'b000, 5'd0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("rst_readies", 32'(rdy()), 32'd0);
    step();
    check("rst_wb_sel", 32'(wb_sel), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_rd", 32'(rf_rd), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    rst = 1'b0;
    // counters must restart from zero: ld wins four times before md is promoted
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("post_rst%0d_ready", i), 32'(rdy()), (i < 4) ? 32'b100 : 32'b010);
      step();
    end
    drive_idle();
    step();

`ifdef WB_SCOREBOARD_EN
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    check("sb_set", 32'(rd_busy[7]), 32'd1);
    drive(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 3'b000, 5'd0);
    step();
    drive_idle();
    issue_valid = 1'b1; issue_rd = 5'd7;  // coincides with the registered write of rd 7
    step();
    issue_valid = 1'b0;
    check("sb_set_wins", 32'(rd_busy[7]), 32'd1);
    drive(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 3'b000, 5'd0);
    step();
    drive_idle();
    check("sb_still_busy", 32'(rd_busy[7]), 32'd1);
    step();
    check("sb_cleared", rd_busy, 32'd0);
`else
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    step();
    issue_valid = 1'b0;
    check("sb_disabled", rd_busy, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
